data_loader_sequencer: RTL and testbench
========================================

DATA_LOADER_SEQUENCER -- requirements
Module: data_loader_sequencer

Interface
REQ-001 SHALL have parameter N_SAMPLES, default 150: number of samples per frame.
REQ-002 SHALL have parameter IDX_W, default 8: index width; elaboration error if 2**IDX_W < N_SAMPLES.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have port start  in  1  frame request; sampled only in IDLE.
REQ-006 SHALL have port in_valid  in  1  sample present on datapath x/y buses.
REQ-007 SHALL have port in_ready  out  1  sequencer accepting samples.
REQ-008 SHALL have port register_load_select  out  IDX_W  bank write index.
REQ-009 SHALL have port load_en  out  1  bank write strobe (decoder enable).
REQ-010 SHALL have port output_select  out  IDX_W  bank read index.
REQ-011 SHALL have port reset_avg  out  1  synchronous accumulator clear, active-high.
REQ-012 SHALL have port load_avg  out  1  accumulator add enable.
REQ-013 SHALL have port select  out  1  output mux: 1 = average, 0 = bank data.
REQ-014 SHALL have port out_valid  out  1  datapath output valid to consumer.
REQ-015 SHALL have port out_ready  in  1  consumer accepts output.
REQ-016 SHALL have port enable_coefficient_calculator_module  out  1  one-cycle pulse, average available.
REQ-017 SHALL have port busy  out  1  high in every state except IDLE.
REQ-018 SHALL have port done  out  1  one-cycle pulse, frame complete.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, AVG_INIT, AVG, SEND_AVG, SEND_DATA with a single IDX_W-bit registered counter cnt; all outputs are decoded from state and cnt.
REQ-020 IDLE: in_ready=0, load_en=0; start=1 -> LOAD, cnt<=0; start while not IDLE SHALL be ignored.
REQ-021 LOAD: in_ready=1, register_load_select=cnt, load_en=in_valid; on in_valid cnt increments; in_valid with cnt==N_SAMPLES-1 -> AVG_INIT, cnt<=0; in_valid=0 holds state and cnt (stall of any length).
REQ-022 AVG_INIT: exactly one cycle, reset_avg=1, load_avg=0, output_select=0 -> AVG.
REQ-023 AVG: load_avg=1, output_select=cnt, cnt increments every cycle; cnt==N_SAMPLES-1 -> SEND_AVG, cnt<=0; exactly N_SAMPLES load_avg cycles per frame.
REQ-024 SEND_AVG: select=1, out_valid=1, load_avg=0; enable_coefficient_calculator_module=1 only on the first cycle in SEND_AVG; out_valid&&out_ready -> SEND_DATA, cnt<=0; otherwise hold.
REQ-025 SEND_DATA: select=0, out_valid=1, output_select=cnt; out_ready increments cnt; out_ready with cnt==N_SAMPLES-1 -> IDLE with done=1 in that same cycle.
REQ-026 Outside the owning state: load_en, reset_avg, load_avg, out_valid, in_ready, select, pulses SHALL be 0; register_load_select and output_select SHALL be 0.
REQ-027 cnt SHALL never exceed N_SAMPLES-1; no wrap-around or out-of-range index SHALL ever be driven.
REQ-028 Minimum frame latency with in_valid and out_ready held high: start edge to done = 3*N_SAMPLES+2 cycles (N LOAD, 1 AVG_INIT, N AVG, 1 SEND_AVG, N SEND_DATA, minus overlap of final SEND_DATA cycle).
REQ-029 start=1 in the cycle done fires SHALL not be accepted; a new frame starts on a start sampled in IDLE afterwards.

Reset
REQ-030 reset=0 SHALL immediately force IDLE, cnt=0, all outputs 0, regardless of clk.
REQ-031 Reset mid-frame SHALL abandon the frame with no done or coefficient pulse; on release the block waits for a fresh start.
REQ-032 First state change after release SHALL occur no earlier than the first rising clk edge with reset=1.

Verification
REQ-033 N=150, start pulse, in_valid and out_ready held 1 -> 150 load_en strokes indices 0..149, one reset_avg, 150 load_avg, one coefficient pulse, 151 out_valid handshakes, done at cycle 452.
REQ-034 in_valid toggled 1/0 during LOAD -> exactly 150 load_en, register_load_select advances only on in_valid, no index skipped or repeated.
REQ-035 out_ready held 0 for 10 cycles in SEND_AVG and at index 73 of SEND_DATA -> select/output_select stable, out_valid held, coefficient pulse still exactly one cycle.
REQ-036 reset=0 asserted mid-clock at AVG cnt=40 -> outputs 0 immediately, no done; later start runs a complete normal frame.
REQ-037 start asserted during LOAD and in done cycle -> ignored; busy stays 1 until done, then 0.
REQ-038 N_SAMPLES=4, IDX_W=2 -> frame completes in 14 cycles, indices 0..3 only.

Source files
------------

// File: rtl/data_loader_sequencer.sv
// Frame sequencer for the sample bank and averager: loads N samples, averages them,
// then streams the average followed by every stored sample to the consumer.
module data_loader_sequencer #(
   parameter int N_SAMPLES = 150,
   parameter int IDX_W     = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [IDX_W-1:0] register_load_select,
   output logic             load_en,
   output logic [IDX_W-1:0] output_select,
   output logic             reset_avg,
   output logic             load_avg,
   output logic             select,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             enable_coefficient_calculator_module,
   output logic             busy,
   output logic             done
);

   if (N_SAMPLES < 2 || (2 ** IDX_W) < N_SAMPLES) begin : g_bad_params
      $error("data_loader_sequencer: N_SAMPLES must be >= 2 and fit in IDX_W bits");
   end

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      AVG_INIT,
      AVG,
      SEND_AVG,
      SEND_DATA
   } state_t;

   localparam logic [IDX_W-1:0] LAST = IDX_W'(N_SAMPLES - 1);
   localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

   state_t           state;
   state_t           next_state;
   logic [IDX_W-1:0] cnt;
   logic [IDX_W-1:0] next_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
      end
   end

   // In SEND_AVG cnt moves to 1 on a stall so the coefficient pulse stays one cycle wide.
   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      case (state)
         IDLE: begin
            next_cnt = '0;
            if (start) begin
               next_state = LOAD;
            end
         end
         LOAD: begin
            if (in_valid) begin
               if (cnt == LAST) begin
                  next_state = AVG_INIT;
                  next_cnt   = '0;
               end else begin
                  next_cnt = cnt + ONE;
               end
            end
         end
         AVG_INIT: begin
            next_state = AVG;
            next_cnt   = '0;
         end
         AVG: begin
            if (cnt == LAST) begin
               next_state = SEND_AVG;
               next_cnt   = '0;
            end else begin
               next_cnt = cnt + ONE;
            end
         end
         SEND_AVG: begin
            if (out_ready) begin
               next_state = SEND_DATA;
               next_cnt   = '0;
            end else begin
               next_cnt = ONE;
            end
         end
         SEND_DATA: begin
            if (out_ready) begin
               if (cnt == LAST) begin
                  next_state = IDLE;
                  next_cnt   = '0;
               end else begin
                  next_cnt = cnt + ONE;
               end
            end
         end
         default: begin
            next_state = IDLE;
            next_cnt   = '0;
         end
      endcase
   end

   always_comb begin
      in_ready                             = 1'b0;
      register_load_select                 = '0;
      load_en                              = 1'b0;
      output_select                        = '0;
      reset_avg                            = 1'b0;
      load_avg                             = 1'b0;
      select                               = 1'b0;
      out_valid                            = 1'b0;
      enable_coefficient_calculator_module = 1'b0;
      busy                                 = (state != IDLE);
      done                                 = 1'b0;
      case (state)
         LOAD: begin
            in_ready             = 1'b1;
            register_load_select = cnt;
            load_en              = in_valid;
         end
         AVG_INIT: begin
            reset_avg = 1'b1;
         end
         AVG: begin
            load_avg      = 1'b1;
            output_select = cnt;
         end
         SEND_AVG: begin
            select                               = 1'b1;
            out_valid                            = 1'b1;
            enable_coefficient_calculator_module = (cnt == '0);
         end
         SEND_DATA: begin
            out_valid     = 1'b1;
            output_select = cnt;
            done          = out_ready && (cnt == LAST);
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_data_loader_sequencer.sv
// Randomized bench for data_loader_sequencer: a transaction-level scoreboard tracks
// load strokes, averaging strokes and output handshakes against the frame rules.
module tb_data_loader_sequencer;

   localparam int N   = 150;
   localparam int IW  = 8;
   localparam int NS  = 4;
   localparam int IWS = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic          start;
   logic          in_valid;
   logic          in_ready;
   logic [IW-1:0] register_load_select;
   logic          load_en;
   logic [IW-1:0] output_select;
   logic          reset_avg;
   logic          load_avg;
   logic          select;
   logic          out_valid;
   logic          out_ready;
   logic          coef;
   logic          busy;
   logic          done;

   logic           s_start;
   logic           s_in_valid;
   logic           s_in_ready;
   logic [IWS-1:0] s_register_load_select;
   logic           s_load_en;
   logic [IWS-1:0] s_output_select;
   logic           s_reset_avg;
   logic           s_load_avg;
   logic           s_select;
   logic           s_out_valid;
   logic           s_out_ready;
   logic           s_coef;
   logic           s_busy;
   logic           s_done;

   data_loader_sequencer #(.N_SAMPLES(N), .IDX_W(IW)) dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .register_load_select(register_load_select), .load_en(load_en),
      .output_select(output_select), .reset_avg(reset_avg), .load_avg(load_avg),
      .select(select), .out_valid(out_valid), .out_ready(out_ready),
      .enable_coefficient_calculator_module(coef), .busy(busy), .done(done)
   );

   data_loader_sequencer #(.N_SAMPLES(NS), .IDX_W(IWS)) dut_small (
      .clk(clk), .reset(reset), .start(s_start), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .register_load_select(s_register_load_select), .load_en(s_load_en),
      .output_select(s_output_select), .reset_avg(s_reset_avg), .load_avg(s_load_avg),
      .select(s_select), .out_valid(s_out_valid), .out_ready(s_out_ready),
      .enable_coefficient_calculator_module(s_coef), .busy(s_busy), .done(s_done)
   );

   logic [24:0] all_outs;
   logic [12:0] s_all_outs;
   assign all_outs = {in_ready, register_load_select, load_en, output_select, reset_avg,
                      load_avg, select, out_valid, coef, busy, done};
   assign s_all_outs = {s_in_ready, s_register_load_select, s_load_en, s_output_select,
                        s_reset_avg, s_load_avg, s_select, s_out_valid, s_coef, s_busy, s_done};

   int checks = 0;
   int errors = 0;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Scoreboard state: frame activity plus per-frame stroke and handshake tallies.
   bit            model_active = 1'b0;
   int            load_cnt     = 0;
   int            avg_cnt      = 0;
   int            rst_avg_cnt  = 0;
   int            coef_cnt     = 0;
   int            hs_cnt       = 0;
   int            done_cnt     = 0;
   bit            prev_stall   = 1'b0;
   logic          prev_select  = 1'b0;
   logic [IW-1:0] prev_osel    = '0;
   bit            mon_hs;
   bit            mon_exp_done;

   always @(negedge clk) begin
      if (!reset) begin
         checkOutput("reset_outputs_zero", all_outs, 0);
         model_active = 1'b0;
         prev_stall   = 1'b0;
      end else begin
         checkOutput("busy", busy, model_active);
         if (!model_active) checkOutput("idle_outputs_zero", all_outs, 0);
         checkOutput("load_en_decode", load_en, in_ready && in_valid);
         if (!in_ready) checkOutput("rls_zero_outside_load", register_load_select, 0);
         if (load_en) begin
            checkOutput("load_index", register_load_select, load_cnt);
            load_cnt++;
         end
         if (reset_avg) begin
            checkOutput("avg_init_osel", output_select, 0);
            checkOutput("avg_init_after_load", load_cnt, N);
            rst_avg_cnt++;
         end
         if (load_avg) begin
            checkOutput("avg_index", output_select, avg_cnt);
            checkOutput("avg_after_init", rst_avg_cnt, 1);
            avg_cnt++;
         end
         if (coef) begin
            checkOutput("coef_with_avg_out", {out_valid, select}, 2'b11);
            checkOutput("coef_after_avg", avg_cnt, N);
            coef_cnt++;
         end
         if (!load_avg && !(out_valid && !select)) checkOutput("osel_zero", output_select, 0);
         if (prev_stall) begin
            checkOutput("stall_out_valid", out_valid, 1);
            checkOutput("stall_select", select, prev_select);
            checkOutput("stall_osel", output_select, prev_osel);
            checkOutput("stall_no_repeat_coef", coef, 0);
         end
         mon_hs       = out_valid && out_ready;
         mon_exp_done = mon_hs && (hs_cnt == N);
         if (mon_hs) begin
            if (hs_cnt == 0) begin
               checkOutput("hs_avg_select", select, 1);
               checkOutput("hs_avg_after_coef", coef_cnt, 1);
            end else begin
               checkOutput("hs_data_select", select, 0);
               checkOutput("hs_data_index", output_select, hs_cnt - 1);
            end
            hs_cnt++;
         end
         checkOutput("done", done, mon_exp_done);
         if (done) done_cnt++;
         prev_stall  = out_valid && !out_ready;
         prev_select = select;
         prev_osel   = output_select;
         if (model_active) begin
            model_active = !mon_exp_done;
         end else if (start) begin
            model_active = 1'b1;
            load_cnt     = 0;
            avg_cnt      = 0;
            rst_avg_cnt  = 0;
            coef_cnt     = 0;
            hs_cnt       = 0;
         end
      end
   end

   bit stall_mode;
   int stall_left;
   bit stalled_avg;
   bit stalled_73;

   // Drives one cycle of inputs just after the rising edge; stall mode reacts to the outputs.
   task automatic applyStimulus(input int valid_pct, input int ready_pct, input bit hold_start,
                                input bit rand_start);
      in_valid = ($urandom_range(99) < valid_pct);
      start    = hold_start ? 1'b1 : (rand_start ? 1'($urandom_range(1)) : 1'b0);
      if (stall_left > 0) begin
         out_ready = 1'b0;
         stall_left--;
      end else if (stall_mode && out_valid && select && !stalled_avg) begin
         stalled_avg = 1'b1;
         stall_left  = 9;
         out_ready   = 1'b0;
      end else if (stall_mode && out_valid && !select && output_select == 8'd73 && !stalled_73) begin
         stalled_73 = 1'b1;
         stall_left = 9;
         out_ready  = 1'b0;
      end else begin
         out_ready = ($urandom_range(99) < ready_pct);
      end
   endtask

   task automatic runFrame(input int valid_pct, input int ready_pct, input bit hold_start,
                           input bit rand_start, input bit stalls, input int exp_latency);
      int cyc;
      bit seen;
      stall_mode  = stalls;
      stall_left  = 0;
      stalled_avg = 1'b0;
      stalled_73  = 1'b0;
      seen        = 1'b0;
      @(posedge clk); #1;
      start     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(posedge clk); #1;
      applyStimulus(valid_pct, ready_pct, hold_start, rand_start);
      cyc = 1;
      while (cyc < 20000) begin
         @(negedge clk); #1;
         if (done) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk); #1;
         applyStimulus(valid_pct, ready_pct, hold_start, rand_start);
         cyc++;
      end
      checkOutput("frame_done_seen", seen, 1);
      if (exp_latency > 0) checkOutput("frame_latency", cyc, exp_latency);
      checkOutput("total_load_en", load_cnt, N);
      checkOutput("total_reset_avg", rst_avg_cnt, 1);
      checkOutput("total_load_avg", avg_cnt, N);
      checkOutput("total_coef", coef_cnt, 1);
      checkOutput("total_handshakes", hs_cnt, N + 1);
      @(posedge clk); #1;
      start     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      stall_mode = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   task automatic runResetMidFrame();
      int cyc;
      bit hit;
      int done_before;
      hit = 1'b0;
      @(posedge clk); #1;
      start     = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (cyc = 0; cyc < 1000; cyc++) begin
         @(negedge clk); #1;
         if (load_avg && output_select == 8'd40) begin
            hit = 1'b1;
            break;
         end
      end
      checkOutput("reached_avg_40", hit, 1);
      done_before = done_cnt;
      #1 reset = 1'b0;
      #1;
      checkOutput("async_reset_immediate", all_outs, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      checkOutput("no_done_after_abort", done_cnt, done_before);
      checkOutput("idle_after_release", busy, 0);
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   task automatic runSmall();
      int cyc;
      int idx;
      int hs;
      bit seen;
      idx  = 0;
      hs   = 0;
      seen = 1'b0;
      @(posedge clk); #1;
      s_start     = 1'b1;
      s_in_valid  = 1'b1;
      s_out_ready = 1'b1;
      @(posedge clk); #1;
      s_start = 1'b0;
      cyc = 1;
      while (cyc < 200) begin
         @(negedge clk); #1;
         if (s_load_en) begin
            checkOutput("small_load_index", s_register_load_select, idx);
            idx++;
         end
         if (s_out_valid && s_out_ready) begin
            if (hs > 0) checkOutput("small_data_index", s_output_select, hs - 1);
            hs++;
         end
         if (s_done) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk); #1;
         cyc++;
      end
      checkOutput("small_done_seen", seen, 1);
      checkOutput("small_latency", cyc, 14);
      checkOutput("small_load_total", idx, NS);
      checkOutput("small_handshakes", hs, NS + 1);
      @(posedge clk); #1;
      s_in_valid  = 1'b0;
      s_out_ready = 1'b0;
      repeat (2) @(posedge clk); #1;
      checkOutput("small_idle_after", s_busy, 0);
   endtask

   initial begin
      reset       = 1'b0;
      start       = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      s_start     = 1'b0;
      s_in_valid  = 1'b0;
      s_out_ready = 1'b0;
      #1;
      checkOutput("reset_state", all_outs, 0);
      checkOutput("small_reset_state", s_all_outs, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);

      runFrame(100, 100, 1'b1, 1'b0, 1'b0, 3 * N + 2);
      runFrame(50, 100, 1'b0, 1'b1, 1'b0, -1);
      runFrame(60, 60, 1'b0, 1'b1, 1'b0, -1);
      runFrame(80, 40, 1'b0, 1'b1, 1'b0, -1);
      runFrame(100, 100, 1'b0, 1'b0, 1'b1, 3 * N + 2 + 20);
      runResetMidFrame();
      runFrame(100, 100, 1'b0, 1'b0, 1'b0, 3 * N + 2);
      runSmall();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
